// File: rtl/ram_port_arbiter_if.sv
// Bundle of both requester ports plus the shared RAM port seen by the arbiter.
interface ram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic          lock1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          locked;

  // Arbiter side: takes requests and RAM read data, drives grants and the RAM port.
  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0,
    input  req1, we1, lock1, addr1, wdata1,
    output gnt1, rvalid1, rdata1,
    output ram_addr, ram_wdata, ram_we,
    input  ram_rdata,
    output locked
  );

  // Requester/RAM side: the mirror image of the arbiter view.
  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0,
    output req1, we1, lock1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1,
    input  ram_addr, ram_wdata, ram_we,
    output ram_rdata,
    input  locked
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU data port (port 0, fixed priority) and
// the UART loader (port 1), with a starvation limit and bounded locked bursts
// for port 1. Accesses happen in the grant cycle; reads return one cycle later.
module ram_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  ram_port_arbiter_if.slave bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LIMIT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  typedef enum logic {
    ARB   = 1'b0,
    LOCK1 = 1'b1
  } stateT;

  stateT         state_q, state_d;
  logic [WW-1:0] waitCnt_q, waitCnt_d;
  logic [BW-1:0] burstCnt_q, burstCnt_d;
  logic          gnt0, gnt1;
  logic          rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  // Grant decision and next state; nothing is granted while reset is held.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    state_d    = state_q;
    burstCnt_d = burstCnt_q;
    if (!rst) begin
      case (state_q)
        ARB: begin
          if (bus.req0 && bus.req1) begin
            if (waitCnt_q == WAIT_LIMIT) gnt1 = 1'b1;
            else                         gnt0 = 1'b1;
          end else begin
            gnt0 = bus.req0;
            gnt1 = bus.req1;
          end
          burstCnt_d = '0;
          if (gnt1 && bus.lock1 && (MAX_BURST > 1)) begin
            state_d    = LOCK1;
            burstCnt_d = BW'(1);
          end
        end
        LOCK1: begin
          gnt1 = bus.req1;
          if (!bus.req1) begin
            state_d    = ARB;
            burstCnt_d = '0;
          end else begin
            burstCnt_d = burstCnt_q + 1'b1;
            if (!bus.lock1 || (burstCnt_d == BURST_LIMIT)) begin
              state_d    = ARB;
              burstCnt_d = '0;
            end
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  // Starvation counter: counts refused port 1 cycles, saturating at the limit.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (gnt1 || !bus.req1)            waitCnt_d = '0;
    else if (waitCnt_q != WAIT_LIMIT) waitCnt_d = waitCnt_q + 1'b1;
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      waitCnt_q  <= '0;
      burstCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      burstCnt_q <= burstCnt_d;
    end
  end

  // Read return: capture the asynchronous RAM data at the end of a read grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 && !bus.we0;
      rvalid1_q <= gnt1 && !bus.we1;
      if (gnt0 && !bus.we0) rdata0_q <= bus.ram_rdata;
      if (gnt1 && !bus.we1) rdata1_q <= bus.ram_rdata;
    end
  end

  // RAM port mux: the winner drives the port, otherwise it idles at zero.
  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    if (gnt0) begin
      bus.ram_addr  = bus.addr0;
      bus.ram_wdata = bus.wdata0;
      bus.ram_we    = bus.we0;
    end else if (gnt1) begin
      bus.ram_addr  = bus.addr1;
      bus.ram_wdata = bus.wdata1;
      bus.ram_we    = bus.we1;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.locked  = (state_q == LOCK1);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: stimulus pushes expected grants and
// read data, a negedge monitor pops and compares whenever the DUT responds.
module tb_ram_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_WAIT(4), .MAX_BURST(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic          locked;
  } grantT;

  grantT         expGrant[$];
  logic [DW-1:0] expRd0[$];
  logic [DW-1:0] expRd1[$];
  grantT         gotG;
  grantT         expG;
  logic [DW-1:0] expD;
  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] mem [0:255];

  assign bus.ram_rdata = mem[bus.ram_addr[7:0]];

  // RAM model: preload known words, then write on the clock edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h02] = 32'hF0F0F0F0;
    mem[8'h04] = 32'h44444444;
    mem[8'h30] = 32'h30303030;
    forever begin
      @(posedge clk);
      if (bus.ram_we) mem[bus.ram_addr[7:0]] = bus.ram_wdata;
    end
  end

  function automatic void pushGrant(input logic port, input logic [AW-1:0] addr,
                                    input logic we, input logic [DW-1:0] wdata,
                                    input logic lockedExp);
    grantT g;
    g.port   = port;
    g.addr   = addr;
    g.we     = we;
    g.wdata  = wdata;
    g.locked = lockedExp;
    expGrant.push_back(g);
  endfunction

  task automatic applyStimulus(input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0, input logic r1, input logic w1,
                               input logic l1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1);
    bus.req0   = r0;
    bus.we0    = w0;
    bus.addr0  = a0;
    bus.wdata0 = d0;
    bus.req1   = r1;
    bus.we1    = w1;
    bus.lock1  = l1;
    bus.addr1  = a1;
    bus.wdata1 = d1;
  endtask

  task automatic checkOutput(input string name, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Monitor: every grant and every rvalid must match the head of its queue.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.gnt0 || bus.gnt1) begin
          checks++;
          gotG.port   = bus.gnt1;
          gotG.addr   = bus.ram_addr;
          gotG.we     = bus.ram_we;
          gotG.wdata  = bus.ram_wdata;
          gotG.locked = bus.locked;
          if (bus.gnt0 && bus.gnt1) begin
            errors++;
            $display("[TB] FAIL grant_exclusive: got gnt0=1 gnt1=1, expected one grant");
          end else if (expGrant.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_grant: got port=%0d addr=%h, expected no grant",
                     gotG.port, gotG.addr);
          end else begin
            expG = expGrant.pop_front();
            if (gotG !== expG) begin
              errors++;
              $display("[TB] FAIL grant_seq: got port=%0d addr=%h we=%0d wdata=%h locked=%0d, expected port=%0d addr=%h we=%0d wdata=%h locked=%0d",
                       gotG.port, gotG.addr, gotG.we, gotG.wdata, gotG.locked,
                       expG.port, expG.addr, expG.we, expG.wdata, expG.locked);
            end
          end
        end
        if (bus.rvalid0) begin
          if (expRd0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid0: got rdata0=%h, expected no rvalid0", bus.rdata0);
          end else begin
            expD = expRd0.pop_front();
            checkOutput("rdata0", bus.rdata0, expD);
          end
        end
        if (bus.rvalid1) begin
          if (expRd1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rvalid1: got rdata1=%h, expected no rvalid1", bus.rdata1);
          end else begin
            expD = expRd1.pop_front();
            checkOutput("rdata1", bus.rdata1, expD);
          end
        end
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h00070010, 32'h11111111,
                  1'b1, 1'b0, 1'b0, 32'h00070011, '0);

    // Reset holds everything quiet even with both ports requesting a write.
    repeat (2) begin
      @(negedge clk);
      checkOutput("rst_gnt0", bus.gnt0, 0);
      checkOutput("rst_gnt1", bus.gnt1, 0);
      checkOutput("rst_ram_we", bus.ram_we, 0);
      checkOutput("rst_ram_addr", bus.ram_addr, 0);
      checkOutput("rst_rvalid0", bus.rvalid0, 0);
      checkOutput("rst_rvalid1", bus.rvalid1, 0);
      checkOutput("rst_rdata0", bus.rdata0, 0);
      checkOutput("rst_rdata1", bus.rdata1, 0);
      checkOutput("rst_locked", bus.locked, 0);
    end
    pushGrant(1'b0, 32'h00070010, 1'b1, 32'h11111111, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    idle();
    checkOutput("t1_write_mem", mem[8'h10], 32'h11111111);
    tick();

    // Port 0 read with one-cycle return and held data.
    pushGrant(1'b0, 32'h00070002, 1'b0, '0, 1'b0);
    expRd0.push_back(32'hF0F0F0F0);
    applyStimulus(1'b1, 1'b0, 32'h00070002, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    idle();
    tick();
    tick();
    checkOutput("t2_rdata0_hold", bus.rdata0, 32'hF0F0F0F0);
    checkOutput("t2_rvalid0_low", bus.rvalid0, 0);

    // Starvation: port 1 wins every fifth cycle.
    for (int i = 1; i <= 10; i++) begin
      if (i % 5 == 0) begin
        pushGrant(1'b1, 32'h00070004, 1'b0, '0, 1'b0);
        expRd1.push_back(32'h44444444);
      end else begin
        pushGrant(1'b0, 32'h00070030, 1'b0, '0, 1'b0);
        expRd0.push_back(32'h30303030);
      end
    end
    applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b0, 1'b0, 32'h00070004, '0);
    repeat (10) tick();
    idle();
    tick();
    tick();

    // Full locked burst of 8 writes, then port 0 wins the tie.
    for (int c = 0; c < 13; c++) begin
      if (c < 4 || c == 12) begin
        pushGrant(1'b0, 32'h00070030, 1'b0, '0, 1'b0);
        expRd0.push_back(32'h30303030);
      end else begin
        pushGrant(1'b1, 32'h00070002 + (c - 4), 1'b1, 32'hA0000000 + (c - 4), (c > 4));
      end
    end
    for (int c = 0; c < 13; c++) begin
      if (c < 12)
        applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b1, 1'b1,
                      32'h00070002 + ((c < 4) ? 0 : (c - 4)),
                      32'hA0000000 + ((c < 4) ? 0 : (c - 4)));
      else
        applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b1, 1'b0,
                      32'h0007000A, 32'hDEADBEEF);
      tick();
    end
    idle();
    checkOutput("t4_locked_after", bus.locked, 0);
    for (int k = 0; k < 8; k++) checkOutput("t4_burst_mem", mem[2 + k], 32'hA0000000 + k);
    checkOutput("t4_no_extra_write", mem[8'h0A], 0);
    tick();
    tick();

    // Early unlock on the third access.
    for (int c = 0; c < 8; c++) begin
      if (c < 4 || c == 7) begin
        pushGrant(1'b0, 32'h00070030, 1'b0, '0, 1'b0);
        expRd0.push_back(32'h30303030);
      end else begin
        pushGrant(1'b1, 32'h00070002 + (c - 4), 1'b1, 32'hB0000000 + (c - 4), (c > 4));
      end
    end
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b1, (c < 6),
                    32'h00070002 + ((c < 4) ? 0 : (c - 4)),
                    32'hB0000000 + ((c < 4) ? 0 : (c - 4)));
      tick();
    end
    idle();
    checkOutput("t5_locked_after", bus.locked, 0);
    for (int k = 0; k < 3; k++) checkOutput("t5_burst_mem", mem[2 + k], 32'hB0000000 + k);
    checkOutput("t5_mem_untouched", mem[5], 32'hA0000003);
    tick();
    tick();

    // Reset during the fourth locked write.
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin
        pushGrant(1'b0, 32'h00070030, 1'b0, '0, 1'b0);
        expRd0.push_back(32'h30303030);
      end else begin
        pushGrant(1'b1, 32'h00070002 + (c - 4), 1'b1, 32'hC0000000 + (c - 4), (c > 4));
      end
    end
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b1, 1'b1,
                    32'h00070002 + ((c < 4) ? 0 : (c - 4)),
                    32'hC0000000 + ((c < 4) ? 0 : (c - 4)));
      tick();
    end
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h00070030, '0, 1'b1, 1'b1, 1'b1, 32'h00070005, 32'hC0000003);
    @(negedge clk);
    checkOutput("t6_rst_gnt0", bus.gnt0, 0);
    checkOutput("t6_rst_gnt1", bus.gnt1, 0);
    checkOutput("t6_rst_ram_we", bus.ram_we, 0);
    pushGrant(1'b0, 32'h00070030, 1'b0, '0, 1'b0);
    expRd0.push_back(32'h30303030);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("t6_mem_unchanged", mem[5], 32'hA0000003);
    for (int k = 0; k < 3; k++) checkOutput("t6_burst_mem", mem[2 + k], 32'hC0000000 + k);
    checkOutput("t6_locked_cleared", bus.locked, 0);
    tick();
    idle();
    tick();
    tick();
    tick();

    checkOutput("sb_grant_drained", expGrant.size(), 0);
    checkOutput("sb_rd0_drained", expRd0.size(), 0);
    checkOutput("sb_rd1_drained", expRd1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one RAM port between two requesters: CPU data port (port 0) and UART loader/sender (port 1).
- Port 0 has fixed priority, bounded by a starvation counter for port 1.
- Port 1 may lock the port for a bounded burst, so a received word stream lands in consecutive cycles.
- Sits between the CPU/UART and port 2 of the shared ram. That RAM port reads asynchronously and writes on the clock edge.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_WAIT, 4, max consecutive cycles port 1 may be refused while requesting before it gets priority (>=1).
- MAX_BURST, 8, max accesses per port 1 locked burst (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  port 0 access request.
- we0  in  1  port 0 write enable (1=write, 0=read).
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 access performed this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DW  port 0 read data.
- req1, we1, addr1, wdata1  in  1/1/AW/DW  port 1 request fields.
- lock1  in  1  port 1 requests to hold the port after this access.
- gnt1, rvalid1, rdata1  out  1/1/DW  port 1 response fields.
- ram_addr  out  AW  RAM address.
- ram_wdata  out  DW  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DW  RAM read data (combinational from ram_addr).
- locked  out  1  high while the FSM is in LOCK1.

Behaviour:
- Clock and reset: one clock, clk; reset is rst, synchronous, active-high.
- Reset values:
  - FSM=ARB, wait_cnt=0, burst_cnt=0.
  - rvalid0=rvalid1=0, rdata0=rdata1=0, locked=0.
  - While rst=1: gnt0=gnt1=0 and ram_we=0, so no write happens in a reset cycle.
- gnt0/gnt1 are combinational from FSM state, counters and requests. They are never both 1. gntX=1 implies reqX=1.
- Access timing:
  - The access happens in the grant cycle. The ram mux selects the winner's addr/wdata, and ram_we = weX of the winner.
  - With no grant: ram_addr=0, ram_wdata=0, ram_we=0.
- Read return:
  - Read granted in cycle t: rdataX <= ram_rdata at the end of t, and rvalidX=1 for exactly cycle t+1.
  - rdataX holds its value until the next read on that port.
  - Writes never assert rvalid.
- FSM state ARB:
  - Only req0: gnt0.
  - Only req1: gnt1.
  - Both, wait_cnt<MAX_WAIT: gnt0.
  - Both, wait_cnt==MAX_WAIT: gnt1.
  - If gnt1 && lock1 && MAX_BURST>1: next state LOCK1, burst_cnt=1.
- FSM state LOCK1 (locked=1):
  - gnt1=req1; gnt0=0 regardless of req0.
  - On each gnt1, burst_cnt increments.
  - Leave to ARB (next cycle) on any of: req1=0; a granted access with lock1=0; a granted access that brings burst_cnt to MAX_BURST.
  - After exit, wait_cnt=0, so port 0 wins any tie in the next ARB cycle. A burst cannot be chained into another burst while req0 is pending.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle with req1=1 && gnt1=0.
  - Clears on gnt1 and whenever req1=0.
- Requester contract: a requester holds req/we/addr/wdata stable until it sees gntX. Dropping req before grant is legal and cancels the access.
- Reset mid-burst: FSM returns to ARB immediately, any in-flight rvalid is cleared, and the pending access is not performed.
- Burst length: a single-access lock (MAX_BURST=1) never enters LOCK1.
- The block has no address decode; ram_addr passes through unmodified.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with req0=req1=1, we0=1 -> gnt0=gnt1=0, ram_we=0, all outputs 0. Release -> gnt0=1 in the first cycle.
2. Port 0 read: req0=1, we0=0, addr0=0x00070002, RAM holds 0xF0F0F0F0 -> gnt0=1 in cycle t, ram_addr=0x00070002; rvalid0=1 and rdata0=0xF0F0F0F0 in t+1 only.
3. Starvation: req0 and req1 held continuously, MAX_WAIT=4 -> gnt0 in 4 cycles, then gnt1 in the 5th; wait_cnt then restarts and gnt1 recurs every 5th cycle.
4. Locked burst: req1=1, lock1=1, writes to 0x00070002.. with req0=1 throughout, MAX_BURST=8 -> 8 consecutive gnt1, locked=1 from the cycle after the 1st grant through the cycle of the 8th; gnt0 in the 9th cycle.
5. Early unlock: same as test 4 but lock1=0 on the 3rd access -> exactly 3 gnt1, then gnt0 next cycle, locked=0.
6. Reset mid-burst: assert rst during the 4th locked write (we1=1, addr1=0x00070005) -> ram_we=0 that cycle and memory is unchanged. After release with req0=1, req1=1 -> gnt0 first, locked=0.
